// File: rtl/axi4lite_bus_arbiter_pkg.sv
// Shared FSM state encodings and master indices for the fetch/LSU AXI4-Lite arbiter.
package axi4lite_arb_types;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;

    typedef logic mst_t;

    localparam mst_t MST_FETCH = 1'b0;
    localparam mst_t MST_LSU   = 1'b1;

endpackage

// File: rtl/axi4lite_if.sv
// AXI4-Lite bundle with master/slave views; carries no logic, so it adds no latency and no backpressure of its own.
interface axi4lite #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  awvalid, awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [2:0]            awprot;
    logic                  wvalid, wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid, bready;
    logic [1:0]            bresp;
    logic                  arvalid, arready;
    logic [ADDR_W-1:0]     araddr;
    logic [2:0]            arprot;
    logic                  rvalid, rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4lite_bus_arbiter_arb2_starve.sv
// Two-way winner pick with a fixed priority master and a saturating starvation counter.
// Combinational winner, counter updates only when the owning channel takes a grant; no backpressure of its own.
module arb2_starve
    import axi4lite_arb_types::*;
#(
    parameter int PRIORITY_MASTER = 1,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output mst_t       winner
);
    localparam mst_t PRI  = (PRIORITY_MASTER != 0) ? MST_LSU : MST_FETCH;
    localparam mst_t NPRI = (PRIORITY_MASTER != 0) ? MST_FETCH : MST_LSU;
    localparam int   CW   = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          contend;

    assign contend = req[0] & req[1];

    always_comb begin
        winner = PRI;
        if (contend) begin
            winner = (STARVE_LIMIT != 0 && starve_cnt == LIMIT) ? NPRI : PRI;
        end else if (req[NPRI]) begin
            winner = NPRI;
        end
    end

    // With a limit of 0 the counter is pinned at 0 and the forced-win branch never fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (take && (|req)) begin
            if (contend && winner == PRI) begin
                if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CW'(1);
            end else begin
                starve_cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/axi4lite_bus_arbiter.sv
// Fetch/LSU to memory AXI4-Lite arbiter: one arbitration cycle, then the granted master's channels pass straight through,
// so backpressure is the slave's ready/valid. Optional AXI4LITE_ARB_PERF_EN adds per-master wait-cycle counters.
module axi4lite_bus_arbiter
    import axi4lite_arb_types::*;
#(
    parameter int PRIORITY_MASTER = 1,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic    clk,
    input  logic    rst,
    axi4lite.slave  m0_bus,
    axi4lite.slave  m1_bus,
    axi4lite.master mem_bus
`ifdef AXI4LITE_ARB_PERF_EN
    ,
    output logic [31:0] m0_wait_cycles,
    output logic [31:0] m1_wait_cycles
`endif
);
    rd_state_t  rd_state;
    wr_state_t  wr_state;
    mst_t       rg, wg, rd_win, wr_win;
    logic       aw_done, w_done, aw_hs, w_hs;
    logic [1:0] rd_req, wr_req;
    logic       rd_addr, rd_data, wr_addr, wr_resp;

    assign rd_req  = {m1_bus.arvalid, m0_bus.arvalid};
    assign wr_req  = {m1_bus.awvalid | m1_bus.wvalid, m0_bus.awvalid | m0_bus.wvalid};
    assign rd_addr = (rd_state == R_ADDR);
    assign rd_data = (rd_state == R_DATA);
    assign wr_addr = (wr_state == W_ADDR);
    assign wr_resp = (wr_state == W_RESP);

    arb2_starve #(.PRIORITY_MASTER(PRIORITY_MASTER), .STARVE_LIMIT(STARVE_LIMIT)) u_rd_arb (
        .clk(clk), .rst(rst), .req(rd_req), .take(rd_state == R_IDLE), .winner(rd_win));

    arb2_starve #(.PRIORITY_MASTER(PRIORITY_MASTER), .STARVE_LIMIT(STARVE_LIMIT)) u_wr_arb (
        .clk(clk), .rst(rst), .req(wr_req), .take(wr_state == W_IDLE), .winner(wr_win));

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rg       <= MST_FETCH;
        end else begin
            case (rd_state)
                R_IDLE: if (|rd_req) begin
                    rg       <= rd_win;
                    rd_state <= R_ADDR;
                end
                R_ADDR: if (mem_bus.arvalid && mem_bus.arready) rd_state <= R_DATA;
                R_DATA: if (mem_bus.rvalid && mem_bus.rready) rd_state <= R_IDLE;
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // AW and W complete independently; leave W_ADDR once both are in, even if they land together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wg       <= MST_FETCH;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: if (|wr_req) begin
                    wg       <= wr_win;
                    wr_state <= W_ADDR;
                end
                W_ADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) wr_state <= W_RESP;
                end
                W_RESP: if (mem_bus.bvalid && mem_bus.bready) begin
                    aw_done  <= 1'b0;
                    w_done   <= 1'b0;
                    wr_state <= W_IDLE;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign mem_bus.arvalid = rd_addr & ((rg == MST_LSU) ? m1_bus.arvalid : m0_bus.arvalid);
    assign mem_bus.araddr  = (rg == MST_LSU) ? m1_bus.araddr : m0_bus.araddr;
    assign mem_bus.arprot  = (rg == MST_LSU) ? m1_bus.arprot : m0_bus.arprot;
    assign mem_bus.rready  = rd_data & ((rg == MST_LSU) ? m1_bus.rready : m0_bus.rready);
    assign m0_bus.arready  = rd_addr & (rg == MST_FETCH) & mem_bus.arready;
    assign m1_bus.arready  = rd_addr & (rg == MST_LSU) & mem_bus.arready;
    assign m0_bus.rvalid   = rd_data & (rg == MST_FETCH) & mem_bus.rvalid;
    assign m1_bus.rvalid   = rd_data & (rg == MST_LSU) & mem_bus.rvalid;
    assign m0_bus.rdata    = mem_bus.rdata;
    assign m1_bus.rdata    = mem_bus.rdata;
    assign m0_bus.rresp    = mem_bus.rresp;
    assign m1_bus.rresp    = mem_bus.rresp;

    assign mem_bus.awvalid = wr_addr & ~aw_done & ((wg == MST_LSU) ? m1_bus.awvalid : m0_bus.awvalid);
    assign mem_bus.awaddr  = (wg == MST_LSU) ? m1_bus.awaddr : m0_bus.awaddr;
    assign mem_bus.awprot  = (wg == MST_LSU) ? m1_bus.awprot : m0_bus.awprot;
    assign mem_bus.wvalid  = wr_addr & ~w_done & ((wg == MST_LSU) ? m1_bus.wvalid : m0_bus.wvalid);
    assign mem_bus.wdata   = (wg == MST_LSU) ? m1_bus.wdata : m0_bus.wdata;
    assign mem_bus.wstrb   = (wg == MST_LSU) ? m1_bus.wstrb : m0_bus.wstrb;
    assign mem_bus.bready  = wr_resp & ((wg == MST_LSU) ? m1_bus.bready : m0_bus.bready);
    assign aw_hs           = mem_bus.awvalid & mem_bus.awready;
    assign w_hs            = mem_bus.wvalid & mem_bus.wready;
    assign m0_bus.awready  = wr_addr & ~aw_done & (wg == MST_FETCH) & mem_bus.awready;
    assign m1_bus.awready  = wr_addr & ~aw_done & (wg == MST_LSU) & mem_bus.awready;
    assign m0_bus.wready   = wr_addr & ~w_done & (wg == MST_FETCH) & mem_bus.wready;
    assign m1_bus.wready   = wr_addr & ~w_done & (wg == MST_LSU) & mem_bus.wready;
    assign m0_bus.bvalid   = wr_resp & (wg == MST_FETCH) & mem_bus.bvalid;
    assign m1_bus.bvalid   = wr_resp & (wg == MST_LSU) & mem_bus.bvalid;
    assign m0_bus.bresp    = mem_bus.bresp;
    assign m1_bus.bresp    = mem_bus.bresp;

`ifdef AXI4LITE_ARB_PERF_EN
    logic m0_waiting, m1_waiting;

    assign m0_waiting = (m0_bus.arvalid && !(rd_state != R_IDLE && rg == MST_FETCH)) ||
                        ((m0_bus.awvalid || m0_bus.wvalid) && !(wr_state != W_IDLE && wg == MST_FETCH));
    assign m1_waiting = (m1_bus.arvalid && !(rd_state != R_IDLE && rg == MST_LSU)) ||
                        ((m1_bus.awvalid || m1_bus.wvalid) && !(wr_state != W_IDLE && wg == MST_LSU));

    always_ff @(posedge clk) begin
        if (rst) begin
            m0_wait_cycles <= '0;
            m1_wait_cycles <= '0;
        end else begin
            if (m0_waiting) m0_wait_cycles <= m0_wait_cycles + 32'd1;
            if (m1_waiting) m1_wait_cycles <= m1_wait_cycles + 32'd1;
        end
    end
`endif

    // A granted master must hold its valids until the forwarded handshake completes.
    ar_valid_held: assert property (@(posedge clk) disable iff (rst)
        rd_addr |-> ((rg == MST_LSU) ? m1_bus.arvalid : m0_bus.arvalid));
    aw_valid_held: assert property (@(posedge clk) disable iff (rst)
        (mem_bus.awvalid && !mem_bus.awready) |=> mem_bus.awvalid);
    w_valid_held: assert property (@(posedge clk) disable iff (rst)
        (mem_bus.wvalid && !mem_bus.wready) |=> mem_bus.wvalid);
endmodule

// File: tb/tb_axi4lite_bus_arbiter.sv
// Directed bench for the fetch/LSU AXI4-Lite arbiter: read vector table plus hand-sequenced write, starvation and reset cases.
module tb_axi4lite_bus_arbiter;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk, rst;
    axi4lite m0_if ();
    axi4lite m1_if ();
    axi4lite mem_if ();

`ifdef AXI4LITE_ARB_PERF_EN
    logic [31:0] m0_wait, m1_wait, p0, p1;
`endif

    axi4lite_bus_arbiter #(.PRIORITY_MASTER(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .m0_bus(m0_if), .m1_bus(m1_if), .mem_bus(mem_if)
`ifdef AXI4LITE_ARB_PERF_EN
        , .m0_wait_cycles(m0_wait), .m1_wait_cycles(m1_wait)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {mem_if.arvalid, mem_if.rready, mem_if.awvalid, mem_if.wvalid, mem_if.bready,
                m0_if.arready, m0_if.rvalid, m0_if.awready, m0_if.wready, m0_if.bvalid,
                m1_if.arready, m1_if.rvalid, m1_if.awready, m1_if.wready, m1_if.bvalid, 1'b0};
    endfunction

    task automatic drive_idle();
        m0_if.arvalid = 0; m0_if.araddr = 0; m0_if.arprot = 0; m0_if.rready = 0;
        m0_if.awvalid = 0; m0_if.awaddr = 0; m0_if.awprot = 0; m0_if.wvalid = 0;
        m0_if.wdata = 0; m0_if.wstrb = 0; m0_if.bready = 0;
        m1_if.arvalid = 0; m1_if.araddr = 0; m1_if.arprot = 0; m1_if.rready = 0;
        m1_if.awvalid = 0; m1_if.awaddr = 0; m1_if.awprot = 0; m1_if.wvalid = 0;
        m1_if.wdata = 0; m1_if.wstrb = 0; m1_if.bready = 0;
        mem_if.arready = 0; mem_if.rvalid = 0; mem_if.rdata = 0; mem_if.rresp = 0;
        mem_if.awready = 0; mem_if.wready = 0; mem_if.bvalid = 0; mem_if.bresp = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic m0_av; logic [31:0] m0_addr; logic m0_rr;
        logic m1_av; logic [31:0] m1_addr; logic m1_rr;
        logic arrdy; logic rv; logic [31:0] rdata; logic [1:0] rresp;
        logic e_av; logic [31:0] e_addr; logic e_m0_ar; logic e_m1_ar;
        logic e_m0_rv; logic e_m1_rv; logic e_rr; logic [31:0] e_rdata; logic [1:0] e_rresp;
    } rd_vec_t;

    rd_vec_t vecs [11];
    logic [5:0] starve_exp;

    initial begin
        // Rows 0-3: lone fetch read; rows 4-10: simultaneous fetch/LSU reads, LSU served first.
        vecs[0]  = '{H, 32'h100, L, L, 32'h0, L, H, L, 32'h0, 2'd0,         L, 32'h0, L, L, L, L, L, 32'h0, 2'd0};
        vecs[1]  = '{H, 32'h100, L, L, 32'h0, L, H, L, 32'h0, 2'd0,         H, 32'h100, H, L, L, L, L, 32'h0, 2'd0};
        vecs[2]  = '{L, 32'h0, H, L, 32'h0, L, L, H, 32'hDEADBEEF, 2'd0,    L, 32'h0, L, L, H, L, H, 32'hDEADBEEF, 2'd0};
        vecs[3]  = '{L, 32'h0, L, L, 32'h0, L, L, L, 32'h0, 2'd0,           L, 32'h0, L, L, L, L, L, 32'h0, 2'd0};
        vecs[4]  = '{H, 32'h100, L, H, 32'h200, L, H, L, 32'h0, 2'd0,       L, 32'h0, L, L, L, L, L, 32'h0, 2'd0};
        vecs[5]  = '{H, 32'h100, L, H, 32'h200, L, H, L, 32'h0, 2'd0,       H, 32'h200, L, H, L, L, L, 32'h0, 2'd0};
        vecs[6]  = '{H, 32'h100, L, L, 32'h0, H, L, H, 32'hAAAA0200, 2'd2,  L, 32'h0, L, L, L, H, H, 32'hAAAA0200, 2'd2};
        vecs[7]  = '{H, 32'h100, L, L, 32'h0, L, H, L, 32'h0, 2'd0,         L, 32'h0, L, L, L, L, L, 32'h0, 2'd0};
        vecs[8]  = '{H, 32'h100, L, L, 32'h0, L, H, L, 32'h0, 2'd0,         H, 32'h100, H, L, L, L, L, 32'h0, 2'd0};
        vecs[9]  = '{L, 32'h0, H, L, 32'h0, H, L, H, 32'hBBBB0100, 2'd0,    L, 32'h0, L, L, H, L, H, 32'hBBBB0100, 2'd0};
        vecs[10] = '{L, 32'h0, L, L, 32'h0, L, L, L, 32'h0, 2'd0,           L, 32'h0, L, L, L, L, L, 32'h0, 2'd0};
        starve_exp = 6'b101111;

        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("reset outputs", 32'(outs()), 32'h0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            m0_if.arvalid = vecs[i].m0_av; m0_if.araddr = vecs[i].m0_addr; m0_if.rready = vecs[i].m0_rr;
            m1_if.arvalid = vecs[i].m1_av; m1_if.araddr = vecs[i].m1_addr; m1_if.rready = vecs[i].m1_rr;
            mem_if.arready = vecs[i].arrdy; mem_if.rvalid = vecs[i].rv;
            mem_if.rdata = vecs[i].rdata; mem_if.rresp = vecs[i].rresp;
`ifdef AXI4LITE_ARB_PERF_EN
            if (i == 4) begin p0 = m0_wait; p1 = m1_wait; end
`endif
            #1;
            check($sformatf("v%0d mem_arvalid", i), 32'(mem_if.arvalid), 32'(vecs[i].e_av));
            if (vecs[i].e_av) check($sformatf("v%0d mem_araddr", i), mem_if.araddr, vecs[i].e_addr);
            check($sformatf("v%0d m0_arready", i), 32'(m0_if.arready), 32'(vecs[i].e_m0_ar));
            check($sformatf("v%0d m1_arready", i), 32'(m1_if.arready), 32'(vecs[i].e_m1_ar));
            check($sformatf("v%0d m0_rvalid", i), 32'(m0_if.rvalid), 32'(vecs[i].e_m0_rv));
            check($sformatf("v%0d m1_rvalid", i), 32'(m1_if.rvalid), 32'(vecs[i].e_m1_rv));
            check($sformatf("v%0d mem_rready", i), 32'(mem_if.rready), 32'(vecs[i].e_rr));
            if (vecs[i].e_m0_rv) begin
                check($sformatf("v%0d m0_rdata", i), m0_if.rdata, vecs[i].e_rdata);
                check($sformatf("v%0d m0_rresp", i), 32'(m0_if.rresp), 32'(vecs[i].e_rresp));
            end
            if (vecs[i].e_m1_rv) begin
                check($sformatf("v%0d m1_rdata", i), m1_if.rdata, vecs[i].e_rdata);
                check($sformatf("v%0d m1_rresp", i), 32'(m1_if.rresp), 32'(vecs[i].e_rresp));
            end
        end
`ifdef AXI4LITE_ARB_PERF_EN
        check("perf m0_wait_cycles", m0_wait - p0, 32'd4);
        check("perf m1_wait_cycles", m1_wait - p1, 32'd1);
`endif

        // Starvation: both masters keep arvalid high; LSU wins four times, then fetch once.
        reset_dut();
        m0_if.arvalid = 1; m0_if.araddr = 32'h100; m0_if.rready = 1;
        m1_if.arvalid = 1; m1_if.araddr = 32'h200; m1_if.rready = 1;
        mem_if.arready = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("starve grant %0d", k), 32'({m1_if.arready, m0_if.arready}),
                  starve_exp[k] ? 32'h2 : 32'h1);
            check($sformatf("starve araddr %0d", k), mem_if.araddr, starve_exp[k] ? 32'h200 : 32'h100);
            @(negedge clk);
            mem_if.rvalid = 1; mem_if.rdata = 32'(k);
            @(negedge clk);
            mem_if.rvalid = 0;
        end

        // Concurrent fetch read and LSU write; slave takes W before AW and raises bvalid early.
        reset_dut();
        m0_if.arvalid = 1; m0_if.araddr = 32'h300;
        m1_if.awvalid = 1; m1_if.awaddr = 32'h40; m1_if.wvalid = 1; m1_if.wdata = 32'h1234; m1_if.wstrb = 4'hF;
        #1 check("wr idle mem_awvalid", 32'(mem_if.awvalid), 32'h0);
        @(negedge clk);
        mem_if.arready = 1; mem_if.wready = 1;
        #1;
        check("conc mem_arvalid", 32'(mem_if.arvalid), 32'h1);
        check("conc mem_araddr", mem_if.araddr, 32'h300);
        check("conc mem_awvalid", 32'(mem_if.awvalid), 32'h1);
        check("conc mem_awaddr", mem_if.awaddr, 32'h40);
        check("conc mem_wvalid", 32'(mem_if.wvalid), 32'h1);
        check("conc mem_wdata", mem_if.wdata, 32'h1234);
        check("conc mem_wstrb", 32'(mem_if.wstrb), 32'hF);
        check("conc m1 aw/w ready", 32'({m1_if.awready, m1_if.wready}), 32'h1);
        @(negedge clk);
        m0_if.arvalid = 0; m0_if.rready = 1; mem_if.arready = 0;
        mem_if.rvalid = 1; mem_if.rdata = 32'h5555;
        mem_if.wready = 0; mem_if.awready = 1; mem_if.bvalid = 1;
        #1;
        check("w done masks mem_wvalid", 32'(mem_if.wvalid), 32'h0);
        check("w done masks m1_wready", 32'(m1_if.wready), 32'h0);
        check("aw after w m1_awready", 32'(m1_if.awready), 32'h1);
        check("early b not forwarded", 32'(m1_if.bvalid), 32'h0);
        check("conc m0_rvalid", 32'(m0_if.rvalid), 32'h1);
        check("conc m0_rdata", m0_if.rdata, 32'h5555);
        @(negedge clk);
        m0_if.rready = 0; mem_if.rvalid = 0;
        m1_if.awvalid = 0; m1_if.wvalid = 0; m1_if.bready = 1; mem_if.awready = 0; mem_if.bresp = 2'd0;
        #1;
        check("resp m1_bvalid", 32'(m1_if.bvalid), 32'h1);
        check("resp mem_bready", 32'(mem_if.bready), 32'h1);
        check("resp m0_bvalid", 32'(m0_if.bvalid), 32'h0);
        check("resp m1_bresp", 32'(m1_if.bresp), 32'h0);
        @(negedge clk);
        drive_idle();
        #1 check("after b outputs", 32'(outs()), 32'h0);

        // Fetch write where AW and W handshake in the same cycle; SLVERR passed through.
        @(negedge clk);
        m0_if.awvalid = 1; m0_if.awaddr = 32'h80; m0_if.wvalid = 1; m0_if.wdata = 32'hCAFE; m0_if.wstrb = 4'h3;
        mem_if.awready = 1; mem_if.wready = 1;
        @(negedge clk);
        #1 check("same-cycle m0 aw/w ready", 32'({m0_if.awready, m0_if.wready}), 32'h3);
        @(negedge clk);
        m0_if.awvalid = 0; m0_if.wvalid = 0; m0_if.bready = 1;
        mem_if.bvalid = 1; mem_if.bresp = 2'd2;
        #1;
        check("same-cycle m0_bvalid", 32'(m0_if.bvalid), 32'h1);
        check("same-cycle m0_bresp", 32'(m0_if.bresp), 32'h2);
        check("same-cycle mem_awvalid", 32'(mem_if.awvalid), 32'h0);

        // Reset while a read sits in R_DATA.
        reset_dut();
        m0_if.arvalid = 1; m0_if.araddr = 32'h500; mem_if.arready = 1;
        @(negedge clk);
        #1 check("pre-rst mem_arvalid", 32'(mem_if.arvalid), 32'h1);
        @(negedge clk);
        m0_if.arvalid = 0; mem_if.arready = 0; mem_if.rvalid = 1; mem_if.rdata = 32'h77;
        #1 check("pre-rst m0_rvalid", 32'(m0_if.rvalid), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; m0_if.rready = 1;
        #1 check("post-rst outputs", 32'(outs()), 32'h0);
        @(negedge clk);
        m0_if.rready = 0; mem_if.rvalid = 0;
        m0_if.arvalid = 1; m0_if.araddr = 32'h600; mem_if.arready = 1;
        #1 check("post-rst arb cycle", 32'(mem_if.arvalid), 32'h0);
        @(negedge clk);
        #1;
        check("post-rst mem_arvalid", 32'(mem_if.arvalid), 32'h1);
        check("post-rst mem_araddr", mem_if.araddr, 32'h600);
        check("post-rst m0_arready", 32'(m0_if.arready), 32'h1);
        @(negedge clk);
        m0_if.arvalid = 0; mem_if.arready = 0; m0_if.rready = 1; mem_if.rvalid = 1; mem_if.rdata = 32'h66;
        #1;
        check("post-rst m0_rvalid", 32'(m0_if.rvalid), 32'h1);
        check("post-rst m0_rdata", m0_if.rdata, 32'h66);
        @(negedge clk);
        drive_idle();
        #1 check("final outputs", 32'(outs()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
